// File: rtl/riscv_data_ram.sv
// riscv_data_ram: word-organised data memory for the single-cycle RISC-V core.
// Synchronous writes and asynchronous reads. Byte addresses select whole words,
// and the address wraps modulo DEPTH*4. A synchronous reset clears every word.
// Optional feature macro: DATA_RAM_BYTE_WE_EN adds per-byte write strobes on port BE.
module riscv_data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
`ifdef DATA_RAM_BYTE_WE_EN
    input  logic [3:0]            BE,
`endif
    output logic [DATA_WIDTH-1:0] RD
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx;

    // Word index; the byte offset and the bits above the index are dropped,
    // which makes misaligned accesses hit the containing word and makes
    // out-of-range addresses wrap.
    assign idx = A[IDX_W+1:2];

    // These address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{A[ADDR_WIDTH-1:IDX_W+2], A[1:0]};

    // Storage update: reset clears every word and takes priority over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE) begin
`ifdef DATA_RAM_BYTE_WE_EN
            for (int k = 0; k < 4; k++) begin
                if (BE[k]) begin
                    mem[idx][8*k +: 8] <= WD[8*k +: 8];
                end
            end
`else
            mem[idx] <= WD;
`endif
        end
    end

    // Read path: combinational, forced to zero when the read is disabled.
    always_comb begin
        RD = RE ? mem[idx] : '0;
    end

endmodule

// File: tb/tb_riscv_data_ram.sv
// tb_riscv_data_ram: self-checking bench for riscv_data_ram with a word-array
// reference model and randomized traffic. Honours DATA_RAM_BYTE_WE_EN.
module tb_riscv_data_ram;

    logic        clk;
    logic        rst;
    logic        WE;
    logic        RE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
`ifdef DATA_RAM_BYTE_WE_EN
    logic [3:0]  BE;
`endif

    int tests_run;
    int tests_failed;

    // Reference model: plain array of words, indexed by byte address / 4 modulo depth.
    logic [31:0] model_mem [1024];

    riscv_data_ram #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .WE(WE),
        .RE(RE),
        .A(A),
        .WD(WD),
`ifdef DATA_RAM_BYTE_WE_EN
        .BE(BE),
`endif
        .RD(RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'd1024);
    endfunction

    function automatic logic [31:0] expected_read(input logic re, input logic [31:0] addr);
        return re ? model_mem[word_of(addr)] : 32'h0;
    endfunction

    // Apply one write over one rising edge and mirror it in the model.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int w;
        @(negedge clk);
        WE = 1'b1;
        A  = addr;
        WD = data;
`ifdef DATA_RAM_BYTE_WE_EN
        BE = be;
`endif
        @(negedge clk);
        WE = 1'b0;
        w = word_of(addr);
`ifdef DATA_RAM_BYTE_WE_EN
        for (int k = 0; k < 4; k++) begin
            if (be[k]) model_mem[w][8*k +: 8] = data[8*k +: 8];
        end
`else
        if (be == be) model_mem[w] = data;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] addr;
        do_reset();
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_reset();
        RE = 1'b1;
        A  = 32'h10;
        #1;
        tests_run++;
        if (RD !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_clear_0x10: got %h expected %h", RD, 32'h0);
        end
        for (int n = 0; n < 8; n++) begin
            addr = $urandom;
            A = addr;
            #1;
            tests_run++;
            if (RD !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_clear_rand A=%h: got %h expected %h", addr, RD, 32'h0);
            end
        end
    endtask

    task automatic test_strided();
        for (int i = 0; i <= 960; i += 64) begin
            do_write(32'(i * 4), 32'(i), 4'hF);
        end
        RE = 1'b1;
        for (int i = 0; i <= 960; i += 64) begin
            A = 32'(i * 4);
            #1;
            tests_run++;
            if (RD !== 32'(i)) begin
                tests_failed++;
                $display("FAIL strided A=%h: got %h expected %h", A, RD, 32'(i));
            end
        end
    endtask

    task automatic test_read_disable_and_same_cycle();
        @(negedge clk);
        RE = 1'b0;
        for (int n = 0; n < 4; n++) begin
            A = $urandom;
            #1;
            tests_run++;
            if (RD !== 32'h0) begin
                tests_failed++;
                $display("FAIL read_disable A=%h: got %h expected %h", A, RD, 32'h0);
            end
        end
        do_write(32'h20, 32'h11, 4'hF);
        @(negedge clk);
        WE = 1'b1;
        RE = 1'b1;
        A  = 32'h20;
        WD = 32'h55;
`ifdef DATA_RAM_BYTE_WE_EN
        BE = 4'hF;
`endif
        #1;
        tests_run++;
        if (RD !== 32'h11) begin
            tests_failed++;
            $display("FAIL same_cycle_before: got %h expected %h", RD, 32'h11);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (RD !== 32'h55) begin
            tests_failed++;
            $display("FAIL same_cycle_after: got %h expected %h", RD, 32'h55);
        end
        @(negedge clk);
        WE = 1'b0;
        model_mem[word_of(32'h20)] = 32'h55;
    endtask

    task automatic test_wrap_misalign();
        do_write(32'h0000_1004, 32'hA5A5A5A5, 4'hF);
        RE = 1'b1;
        A  = 32'h4;
        #1;
        tests_run++;
        if (RD !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL wrap_0x4: got %h expected %h", RD, 32'hA5A5A5A5);
        end
        A = 32'h7;
        #1;
        tests_run++;
        if (RD !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL misalign_0x7: got %h expected %h", RD, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_reset_collision();
        do_write(32'h8, 32'hCAFE0001, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        WE  = 1'b1;
        A   = 32'h8;
        WD  = 32'h1234;
`ifdef DATA_RAM_BYTE_WE_EN
        BE  = 4'hF;
`endif
        @(negedge clk);
        rst = 1'b0;
        WE  = 1'b0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        RE = 1'b1;
        A  = 32'h8;
        #1;
        tests_run++;
        if (RD !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_collision: got %h expected %h", RD, 32'h0);
        end
    endtask

`ifdef DATA_RAM_BYTE_WE_EN
    task automatic test_byte_we();
        do_write(32'h40, 32'h11223344, 4'hF);
        do_write(32'h40, 32'hAABBCCDD, 4'b0101);
        RE = 1'b1;
        A  = 32'h40;
        #1;
        tests_run++;
        if (RD !== 32'h11BB33DD) begin
            tests_failed++;
            $display("FAIL byte_lane: got %h expected %h", RD, 32'h11BB33DD);
        end
        do_write(32'h40, 32'hFFFFFFFF, 4'b0000);
        #1;
        tests_run++;
        if (RD !== 32'h11BB33DD) begin
            tests_failed++;
            $display("FAIL byte_none: got %h expected %h", RD, 32'h11BB33DD);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] exp;
        for (int n = 0; n < 300; n++) begin
            addr = $urandom;
            if (n % 3 != 2) addr = addr & 32'h0000_00FF;  // concentrate traffic to force reuse
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                RE = 1'($urandom_range(0, 3) != 0);
                A  = addr;
                #1;
                exp = expected_read(RE, addr);
                tests_run++;
                if (RD !== exp) begin
                    tests_failed++;
                    $display("FAIL random_read A=%h RE=%b: got %h expected %h", addr, RE, RD, exp);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        WE  = 1'b0;
        RE  = 1'b0;
        A   = 32'h0;
        WD  = 32'h0;
`ifdef DATA_RAM_BYTE_WE_EN
        BE  = 4'hF;
`endif
        test_reset();
        test_strided();
        test_read_disable_and_same_cycle();
        test_wrap_misalign();
        test_reset_collision();
`ifdef DATA_RAM_BYTE_WE_EN
        test_byte_we();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
